// File: rtl/mem_arbiter.sv
// Arbitrates I-cache reads and D-cache reads/writes onto one physical-memory port; D has priority with an I-starvation burst cap.
// Latency: grant one cycle after request, port resp in the same cycle as pmem_resp, at least one idle cycle between grants.
// Backpressure: requesters hold their level request until their resp; pmem stalls simply by withholding pmem_resp.
module mem_arbiter #(
    parameter int ADDR_WIDTH = 16,
    parameter int LINE_WIDTH = 128,
    parameter int D_BURST    = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_mem_read,
    input  logic [ADDR_WIDTH-1:0] i_mem_address,
    output logic [LINE_WIDTH-1:0] i_mem_rdata,
    output logic                  i_mem_resp,
    input  logic                  d_mem_read,
    input  logic                  d_mem_write,
    input  logic [ADDR_WIDTH-1:0] d_mem_address,
    input  logic [LINE_WIDTH-1:0] d_mem_wdata,
    output logic [LINE_WIDTH-1:0] d_mem_rdata,
    output logic                  d_mem_resp,
    output logic                  pmem_read,
    output logic                  pmem_write,
    output logic [ADDR_WIDTH-1:0] pmem_address,
    output logic [LINE_WIDTH-1:0] pmem_wdata,
    input  logic [LINE_WIDTH-1:0] pmem_rdata,
    input  logic                  pmem_resp
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } state_t;

    localparam logic [2:0] D_BURST_LIM = 3'(D_BURST);

    state_t     state;
    state_t     state_nxt;
    logic [2:0] d_streak;
    logic [2:0] d_streak_nxt;
    logic       d_req;

    assign d_req       = d_mem_read | d_mem_write;
    assign i_mem_rdata = pmem_rdata;
    assign d_mem_rdata = pmem_rdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            d_streak <= 3'd0;
        end else begin
            state    <= state_nxt;
            d_streak <= d_streak_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        d_streak_nxt = d_streak;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = '0;
        pmem_wdata   = '0;
        i_mem_resp   = 1'b0;
        d_mem_resp   = 1'b0;
        case (state)
            IDLE: begin
                if (d_req && (!i_mem_read || d_streak < D_BURST_LIM)) begin
                    state_nxt = SERVE_D;
                end else if (i_mem_read) begin
                    state_nxt = SERVE_I;
                end
            end
            SERVE_D: begin
                // Address/data pass through live so an indirect pair's second address lands after the resp.
                pmem_read    = d_mem_read;
                pmem_write   = d_mem_write;
                pmem_address = d_mem_address;
                pmem_wdata   = d_mem_wdata;
                d_mem_resp   = pmem_resp;
                if (pmem_resp) begin
                    state_nxt = IDLE;
                    if (i_mem_read) begin
                        d_streak_nxt = (d_streak == 3'd7) ? 3'd7 : d_streak + 3'd1;
                    end else begin
                        d_streak_nxt = 3'd0;
                    end
                end
            end
            SERVE_I: begin
                pmem_read    = 1'b1;
                pmem_address = i_mem_address;
                i_mem_resp   = pmem_resp;
                if (pmem_resp) begin
                    state_nxt    = IDLE;
                    d_streak_nxt = 3'd0;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter against a transaction-owner reference model, plus directed scenarios.
module tb_mem_arbiter;

    localparam int AW = 16;
    localparam int LW = 128;
    localparam int DB = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          i_mem_read;
    logic [AW-1:0] i_mem_address;
    logic [LW-1:0] i_mem_rdata;
    logic          i_mem_resp;
    logic          d_mem_read;
    logic          d_mem_write;
    logic [AW-1:0] d_mem_address;
    logic [LW-1:0] d_mem_wdata;
    logic [LW-1:0] d_mem_rdata;
    logic          d_mem_resp;
    logic          pmem_read;
    logic          pmem_write;
    logic [AW-1:0] pmem_address;
    logic [LW-1:0] pmem_wdata;
    logic [LW-1:0] pmem_rdata;
    logic          pmem_resp;

    int checks   = 0;
    int failures = 0;

    // Reference: who currently owns the memory port, and how many D completions an I request has sat through.
    typedef enum int {OWN_NONE, OWN_I, OWN_D} owner_t;
    owner_t owner  = OWN_NONE;
    int     d_run  = 0;
    logic   i_seen = 1'b0;
    logic   d_seen = 1'b0;

    mem_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW), .D_BURST(DB)) dut (
        .clk(clk), .reset(reset),
        .i_mem_read(i_mem_read), .i_mem_address(i_mem_address),
        .i_mem_rdata(i_mem_rdata), .i_mem_resp(i_mem_resp),
        .d_mem_read(d_mem_read), .d_mem_write(d_mem_write),
        .d_mem_address(d_mem_address), .d_mem_wdata(d_mem_wdata),
        .d_mem_rdata(d_mem_rdata), .d_mem_resp(d_mem_resp),
        .pmem_read(pmem_read), .pmem_write(pmem_write),
        .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
        .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [LW-1:0] rand_line();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Compare every output with what the owner model implies for the current inputs.
    task automatic settle();
        logic          e_rd, e_wr, e_ir, e_dr;
        logic [AW-1:0] e_addr;
        logic [LW-1:0] e_wd;
        #1;
        e_rd = 1'b0; e_wr = 1'b0; e_ir = 1'b0; e_dr = 1'b0; e_addr = '0; e_wd = '0;
        if (owner == OWN_I) begin
            e_rd = 1'b1; e_addr = i_mem_address; e_ir = pmem_resp;
        end else if (owner == OWN_D) begin
            e_rd = d_mem_read; e_wr = d_mem_write; e_addr = d_mem_address;
            e_wd = d_mem_wdata; e_dr = pmem_resp;
        end
        check("pmem_read", LW'(pmem_read), LW'(e_rd));
        check("pmem_write", LW'(pmem_write), LW'(e_wr));
        check("pmem_address", LW'(pmem_address), LW'(e_addr));
        check("pmem_wdata", pmem_wdata, e_wd);
        check("i_mem_resp", LW'(i_mem_resp), LW'(e_ir));
        check("d_mem_resp", LW'(d_mem_resp), LW'(e_dr));
        check("i_mem_rdata", i_mem_rdata, pmem_rdata);
        check("d_mem_rdata", d_mem_rdata, pmem_rdata);
        i_seen = i_mem_resp;
        d_seen = d_mem_resp;
    endtask

    // Clock edge: advance the model with the inputs held over that edge, then return at the next falling edge.
    task automatic advance();
        logic dq;
        @(posedge clk);
        #1;
        dq = d_mem_read | d_mem_write;
        if (reset) begin
            owner = OWN_NONE;
            d_run = 0;
        end else if (owner == OWN_NONE) begin
            if (dq && (!i_mem_read || d_run < DB)) owner = OWN_D;
            else if (i_mem_read) owner = OWN_I;
        end else if (pmem_resp) begin
            if (owner == OWN_D && i_mem_read) d_run = d_run + 1;
            else d_run = 0;
            owner = OWN_NONE;
        end
        @(negedge clk);
    endtask

    task automatic step();
        settle();
        advance();
    endtask

    initial begin
        reset = 1'b1; i_mem_read = 1'b0; i_mem_address = '0;
        d_mem_read = 1'b0; d_mem_write = 1'b0; d_mem_address = '0; d_mem_wdata = '0;
        pmem_rdata = rand_line(); pmem_resp = 1'b0;
        @(negedge clk);
        step();
        reset = 1'b0;
        settle();
        check("rst_pmem_read", LW'(pmem_read), '0);
        check("rst_pmem_address", LW'(pmem_address), '0);
        advance();

        // Reset during a D read, then a late pmem_resp must be ignored.
        d_mem_read = 1'b1; d_mem_address = 16'h0100;
        step();
        reset = 1'b1;
        settle();
        check("d_strobe_before_rst", LW'(pmem_read), LW'(1));
        advance();
        reset = 1'b0; d_mem_read = 1'b0; pmem_resp = 1'b1;
        settle();
        check("late_resp_ignored", LW'(d_mem_resp), '0);
        check("post_rst_strobe", LW'(pmem_read), '0);
        advance();
        pmem_resp = 1'b0;
        step();

        // Lone I read at 0x1230, three-cycle memory latency.
        i_mem_read = 1'b1; i_mem_address = 16'h1230;
        step();
        settle();
        check("lone_i_addr", LW'(pmem_address), LW'(16'h1230));
        check("lone_i_strobe", LW'(pmem_read), LW'(1));
        advance();
        step();
        pmem_resp = 1'b1; pmem_rdata = 128'hDEADBEEF_0123_4567_89AB_CDEF_DEADBEEF;
        settle();
        check("lone_i_resp", LW'(i_mem_resp), LW'(1));
        check("lone_i_rdata", i_mem_rdata, 128'hDEADBEEF_0123_4567_89AB_CDEF_DEADBEEF);
        check("lone_i_no_dresp", LW'(d_mem_resp), '0);
        advance();
        pmem_resp = 1'b0; i_mem_read = 1'b0;
        step();

        // Simultaneous I read and D write: D goes first, an idle cycle, then I.
        i_mem_read = 1'b1; i_mem_address = 16'h0040;
        d_mem_write = 1'b1; d_mem_address = 16'h2000; d_mem_wdata = {16{8'h55}};
        step();
        settle();
        check("sim_d_write", LW'(pmem_write), LW'(1));
        check("sim_d_addr", LW'(pmem_address), LW'(16'h2000));
        check("sim_d_wdata", pmem_wdata, {16{8'h55}});
        advance();
        pmem_resp = 1'b1;
        settle();
        check("sim_d_resp_first", LW'(d_mem_resp), LW'(1));
        check("sim_i_waits", LW'(i_mem_resp), '0);
        advance();
        pmem_resp = 1'b0; d_mem_write = 1'b0;
        settle();
        check("sim_gap", LW'(pmem_read | pmem_write), '0);
        advance();
        settle();
        check("sim_i_addr", LW'(pmem_address), LW'(16'h0040));
        advance();
        pmem_resp = 1'b1;
        step();
        pmem_resp = 1'b0; i_mem_read = 1'b0;
        step();

        // Random traffic, including mid-service drops, stray pmem_resp pulses and occasional resets.
        for (int c = 0; c < 4000; c++) begin
            if (i_mem_read && i_seen) begin
                i_mem_read = ($urandom_range(1, 0) == 1);
                i_mem_address = AW'($urandom);
            end else if (!i_mem_read && $urandom_range(9, 0) < 4) begin
                i_mem_read = 1'b1;
                i_mem_address = AW'($urandom);
            end else if (i_mem_read && $urandom_range(99, 0) < 2) begin
                i_mem_read = 1'b0;
            end
            if ((d_mem_read | d_mem_write) && d_seen) begin
                // Often keep requesting with a new address, as an indirect pair does.
                if ($urandom_range(2, 0) != 0) begin
                    d_mem_read = $urandom_range(1, 0) == 1;
                    d_mem_write = ~d_mem_read;
                    d_mem_address = AW'($urandom);
                    d_mem_wdata = rand_line();
                end else begin
                    d_mem_read = 1'b0; d_mem_write = 1'b0;
                end
            end else if (!(d_mem_read | d_mem_write) && $urandom_range(9, 0) < 5) begin
                d_mem_read = $urandom_range(1, 0) == 1;
                d_mem_write = ~d_mem_read;
                d_mem_address = AW'($urandom);
                d_mem_wdata = rand_line();
            end else if ((d_mem_read | d_mem_write) && $urandom_range(99, 0) < 2) begin
                d_mem_read = 1'b0; d_mem_write = 1'b0;
            end
            pmem_resp = ($urandom_range(3, 0) == 0);
            pmem_rdata = rand_line();
            reset = ($urandom_range(199, 0) == 0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
